contador_param: RTL and testbench

//  Parametrised bank of per-channel event counters for the transaction layer.

---
 rtl/contador_param.sv | 126 ++++++++++++
 tb/tb_contador_param.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/contador_param.sv
// contador_param
//   Parametrised bank of per-channel event counters with a registered
//   request/index readout.  Each channel counts push strobes; a read returns
//   one channel's count one cycle after the request.
//
//   Parameters
//     NUM_CH       number of counted channels (1..2**IDX_W)
//     CNT_W        counter width in bits
//     IDX_W        width of the channel index
//     SATURATE     0: counters wrap past all-ones; 1: counters hold at all-ones
//     CLR_ON_READ  1: a served read clears the selected counter and its ovf flag
//
//   Ports
//     clk       rising-edge clock
//     reset_L   asynchronous active-low reset
//     push      per-channel increment strobe, one event per cycle high
//     clr_all   synchronous clear of all counters and ovf flags
//     req       read request, sampled every cycle
//     idx       channel selected by req
//     data      registered count of channel idx (pre-increment, pre-clear)
//     valid     data qualifier, high one cycle per served request
//     err_idx   high with valid when idx >= NUM_CH
//     ovf       sticky per-channel overflow flags
module contador_param #(
   parameter int NUM_CH      = 5,
   parameter int CNT_W       = 8,
   parameter int IDX_W       = 3,
   parameter int SATURATE    = 0,
   parameter int CLR_ON_READ = 0
) (
   input  logic              clk,
   input  logic              reset_L,
   input  logic [NUM_CH-1:0] push,
   input  logic              clr_all,
   input  logic              req,
   input  logic [IDX_W-1:0]  idx,
   output logic [CNT_W-1:0]  data,
   output logic              valid,
   output logic              err_idx,
   output logic [NUM_CH-1:0] ovf
);

   localparam logic [IDX_W:0] NUM_CH_L = (IDX_W+1)'(NUM_CH);

   logic [CNT_W-1:0]  cnt     [NUM_CH];
   logic [CNT_W-1:0]  cnt_nxt [NUM_CH];
   logic [NUM_CH-1:0] ovf_nxt;
   logic [NUM_CH-1:0] sel;
   logic [CNT_W-1:0]  rd_val;
   logic              idx_ok;

   // Widened compare so NUM_CH == 2**IDX_W is handled without overflow.
   assign idx_ok = ({1'b0, idx} < NUM_CH_L);

   // One-hot channel select and read mux; out-of-range indices select nothing.
   always_comb begin
      sel    = '0;
      rd_val = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (idx == IDX_W'(i)) begin
            sel[i] = 1'b1;
            rd_val = cnt[i];
         end
      end
   end

   // Per-channel next state.  Priority: clr_all > clear-on-read > push.
   // A served clear-on-read still absorbs a same-cycle push (counter -> 1),
   // and an overflow in that same cycle keeps the ovf flag set.
   always_comb begin
      ovf_nxt = ovf;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         cnt_nxt[i] = cnt[i];
         if (clr_all) begin
            cnt_nxt[i] = '0;
            ovf_nxt[i] = 1'b0;
         end else begin
            if ((CLR_ON_READ != 0) && req && idx_ok && sel[i]) begin
               ovf_nxt[i] = 1'b0;
               cnt_nxt[i] = push[i] ? CNT_W'(1) : '0;
               if (push[i] && (cnt[i] == '1)) begin
                  ovf_nxt[i] = 1'b1;
               end
            end else if (push[i]) begin
               if (cnt[i] == '1) begin
                  ovf_nxt[i] = 1'b1;
                  cnt_nxt[i] = (SATURATE != 0) ? cnt[i] : '0;
               end else begin
                  cnt_nxt[i] = cnt[i] + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt[i] <= '0;
         end
         ovf <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
         ovf <= ovf_nxt;
      end
   end

   // Readout samples the counters before this edge's update, so the value
   // returned is pre-increment and pre-clear.  data holds when req is low.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         data    <= '0;
         valid   <= 1'b0;
         err_idx <= 1'b0;
      end else begin
         valid   <= req;
         err_idx <= req & ~idx_ok;
         if (req) begin
            data <= idx_ok ? rd_val : '0;
         end
      end
   end

endmodule

// File: tb/tb_contador_param.sv
// tb_contador_param
//   Drives three configurations of contador_param from shared stimulus:
//   d0 wrap, d1 saturate, d2 wrap + clear-on-read.  A behavioural model
//   predicts read results into per-instance queues; results are popped and
//   compared when valid appears.
module tb_contador_param;

   localparam int NCH = 5;
   localparam int NDUT = 3;
   localparam int MAXV = 255;

   logic             clk = 1'b0;
   logic             reset_L;
   logic [NCH-1:0]   push;
   logic             clr_all;
   logic             req;
   logic [2:0]       idx;

   logic [7:0]       d_o     [NDUT];
   logic             valid_o [NDUT];
   logic             err_o   [NDUT];
   logic [NCH-1:0]   ovf_o   [NDUT];

   typedef struct {
      logic       err;
      logic [7:0] data;
   } exp_t;

   exp_t        q [NDUT][$];
   int unsigned m_cnt [NDUT][NCH];
   bit          m_ovf [NDUT][NCH];
   logic [7:0]  last_d [NDUT];
   int          sat_p [NDUT] = '{0, 1, 0};
   int          cor_p [NDUT] = '{0, 0, 1};

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   contador_param #(.NUM_CH(NCH), .CNT_W(8), .IDX_W(3), .SATURATE(0), .CLR_ON_READ(0)) d0 (
      .clk(clk), .reset_L(reset_L), .push(push), .clr_all(clr_all), .req(req), .idx(idx),
      .data(d_o[0]), .valid(valid_o[0]), .err_idx(err_o[0]), .ovf(ovf_o[0]));

   contador_param #(.NUM_CH(NCH), .CNT_W(8), .IDX_W(3), .SATURATE(1), .CLR_ON_READ(0)) d1 (
      .clk(clk), .reset_L(reset_L), .push(push), .clr_all(clr_all), .req(req), .idx(idx),
      .data(d_o[1]), .valid(valid_o[1]), .err_idx(err_o[1]), .ovf(ovf_o[1]));

   contador_param #(.NUM_CH(NCH), .CNT_W(8), .IDX_W(3), .SATURATE(0), .CLR_ON_READ(1)) d2 (
      .clk(clk), .reset_L(reset_L), .push(push), .clr_all(clr_all), .req(req), .idx(idx),
      .data(d_o[2]), .valid(valid_o[2]), .err_idx(err_o[2]), .ovf(ovf_o[2]));

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < NDUT; k++) begin
         q[k].delete();
         last_d[k] = '0;
         for (int c = 0; c < NCH; c++) begin
            m_cnt[k][c] = 0;
            m_ovf[k][c] = 1'b0;
         end
      end
   endfunction

   // Model of one clock edge for instance k, taken directly from the behaviour rules.
   function automatic void model_edge(input int k, input logic [NCH-1:0] p, input logic c,
                                      input logic r, input logic [2:0] i);
      exp_t e;
      bit served;
      if (r) begin
         e.err  = (i >= NCH);
         e.data = (i < NCH) ? 8'(m_cnt[k][i]) : 8'd0;
         q[k].push_back(e);
      end
      for (int ch = 0; ch < NCH; ch++) begin
         if (c) begin
            m_cnt[k][ch] = 0;
            m_ovf[k][ch] = 1'b0;
         end else begin
            served = r && (i < NCH) && (cor_p[k] != 0) && (int'(i) == ch);
            if (served) begin
               if (p[ch] && m_cnt[k][ch] == MAXV) m_ovf[k][ch] = 1'b1;
               else m_ovf[k][ch] = 1'b0;
               m_cnt[k][ch] = p[ch] ? 1 : 0;
            end else if (p[ch]) begin
               if (m_cnt[k][ch] == MAXV) begin
                  m_ovf[k][ch] = 1'b1;
                  m_cnt[k][ch] = (sat_p[k] != 0) ? MAXV : 0;
               end else begin
                  m_cnt[k][ch] = m_cnt[k][ch] + 1;
               end
            end
         end
      end
   endfunction

   task automatic compare_outputs();
      exp_t e;
      logic [NCH-1:0] ov;
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("d%0d_valid", k), 32'(valid_o[k]), 32'(q[k].size() != 0));
         if (valid_o[k] && q[k].size() != 0) begin
            e = q[k].pop_front();
            check($sformatf("d%0d_data", k), 32'(d_o[k]), 32'(e.data));
            check($sformatf("d%0d_err_idx", k), 32'(err_o[k]), 32'(e.err));
            last_d[k] = e.data;
         end else begin
            q[k].delete();
            check($sformatf("d%0d_data_hold", k), 32'(d_o[k]), 32'(last_d[k]));
            check($sformatf("d%0d_err_idle", k), 32'(err_o[k]), 32'd0);
         end
         for (int c = 0; c < NCH; c++) ov[c] = m_ovf[k][c];
         check($sformatf("d%0d_ovf", k), 32'(ovf_o[k]), 32'(ov));
      end
   endtask

   // Apply one cycle of stimulus, advance one edge, compare outputs.
   task automatic drive(input logic [NCH-1:0] p, input logic c, input logic r, input logic [2:0] i);
      push = p; clr_all = c; req = r; idx = i;
      for (int k = 0; k < NDUT; k++) model_edge(k, p, c, r, i);
      @(posedge clk);
      #1;
      compare_outputs();
      push = '0; clr_all = 1'b0; req = 1'b0; idx = '0;
   endtask

   task automatic check_all_zero(input string tag);
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("%s_d%0d_data", tag, k), 32'(d_o[k]), 32'd0);
         check($sformatf("%s_d%0d_valid", tag, k), 32'(valid_o[k]), 32'd0);
         check($sformatf("%s_d%0d_err", tag, k), 32'(err_o[k]), 32'd0);
         check($sformatf("%s_d%0d_ovf", tag, k), 32'(ovf_o[k]), 32'd0);
      end
   endtask

   initial begin
      reset_L = 1'b0; push = '0; clr_all = 1'b0; req = 1'b0; idx = '0;
      model_reset();
      #2;
      check_all_zero("reset_init");
      #10 reset_L = 1'b1;
      @(posedge clk); #1;
      check_all_zero("post_release");

      // 1: count ch0 to 7, read it, then reset while the valid is showing.
      repeat (7) drive(5'b00001, 1'b0, 1'b0, 3'd0);
      drive('0, 1'b0, 1'b1, 3'd0);
      check("t1_pre_reset_data", 32'(d_o[0]), 32'd7);
      #2 reset_L = 1'b0;
      #1;
      check_all_zero("t1_async");
      model_reset();
      #10 reset_L = 1'b1;
      @(posedge clk); #1;
      check_all_zero("t1_no_glitch");
      drive('0, 1'b0, 1'b1, 3'd0);
      check("t1_read_after_reset", 32'(d_o[0]), 32'd0);
      check("t1_valid_after_reset", 32'(valid_o[0]), 32'd1);

      // 2: three pushes on ch2, read; read with push; read again.
      repeat (3) drive(5'b00100, 1'b0, 1'b0, 3'd0);
      drive('0, 1'b0, 1'b1, 3'd2);
      check("t2_first_read", 32'(d_o[0]), 32'd3);
      drive(5'b00100, 1'b0, 1'b1, 3'd2);
      check("t2_read_with_push", 32'(d_o[0]), 32'd3);
      drive('0, 1'b0, 1'b1, 3'd2);
      check("t2_read_after_push", 32'(d_o[0]), 32'd4);
      drive('0, 1'b0, 1'b0, 3'd0);
      check("t2_idle_hold", 32'(d_o[0]), 32'd4);

      // 3: 256 pushes on ch1 from zero.
      drive('0, 1'b1, 1'b0, 3'd0);
      repeat (256) drive(5'b00010, 1'b0, 1'b0, 3'd0);
      drive('0, 1'b0, 1'b1, 3'd1);
      check("t3_wrap_data", 32'(d_o[0]), 32'd0);
      check("t3_sat_data", 32'(d_o[1]), 32'd255);
      check("t3_wrap_ovf1", 32'(ovf_o[0][1]), 32'd1);
      check("t3_sat_ovf1", 32'(ovf_o[1][1]), 32'd1);
      drive(5'b00010, 1'b0, 1'b1, 3'd1);
      check("t3_sat_hold", 32'(d_o[1]), 32'd255);

      // 4: clear-on-read with a same-cycle push on ch3.
      drive('0, 1'b1, 1'b0, 3'd0);
      repeat (5) drive(5'b01000, 1'b0, 1'b0, 3'd0);
      drive(5'b01000, 1'b0, 1'b1, 3'd3);
      check("t4_cor_data", 32'(d_o[2]), 32'd5);
      drive('0, 1'b0, 1'b1, 3'd3);
      check("t4_cor_reread", 32'(d_o[2]), 32'd1);
      check("t4_cor_ovf3", 32'(ovf_o[2][3]), 32'd0);
      check("t4_nocor_reread", 32'(d_o[0]), 32'd6);

      // 5: out-of-range indices, then read every channel back.
      drive('0, 1'b0, 1'b1, 3'd6);
      check("t5_bad_data", 32'(d_o[0]), 32'd0);
      check("t5_bad_valid", 32'(valid_o[0]), 32'd1);
      check("t5_bad_err", 32'(err_o[0]), 32'd1);
      drive('0, 1'b0, 1'b1, 3'd5);
      drive('0, 1'b0, 1'b1, 3'd7);
      for (int c = 0; c < NCH; c++) drive('0, 1'b0, 1'b1, 3'(c));

      // 6: clr_all with push and read on ch0 holding 9; ovf[1] set first.
      repeat (256) drive(5'b00010, 1'b0, 1'b0, 3'd0);
      drive('0, 1'b0, 1'b0, 3'd0);
      repeat (9) drive(5'b00001, 1'b0, 1'b0, 3'd0);
      drive(5'b00001, 1'b1, 1'b1, 3'd0);
      check("t6_preclear_data", 32'(d_o[0]), 32'd9);
      drive('0, 1'b0, 1'b1, 3'd0);
      check("t6_postclear_data", 32'(d_o[0]), 32'd0);
      check("t6_ovf_cleared", 32'(ovf_o[0]), 32'd0);

      // Random traffic including back-to-back reads.
      for (int n = 0; n < 400; n++) begin
         drive(5'($urandom), ($urandom_range(0, 39) == 0), 1'($urandom), 3'($urandom_range(0, 7)));
      end
      drive('0, 1'b0, 1'b0, 3'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
